// File: rtl/dmem_responder_pkg.sv
// +--------------------------------------------------------------------+
// | dmem_responder_pkg : FSM state type and width-code helpers         |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none
`include "common.vh"

package dmem_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   function automatic logic width_legal(input logic [2:0] width);
      return (width == `WIDTH_B)  || (width == `WIDTH_H)  || (width == `WIDTH_W) ||
             (width == `WIDTH_BU) || (width == `WIDTH_HU);
   endfunction

   function automatic logic misaligned(input logic [2:0] width, input logic [1:0] offset);
      case (width)
         `WIDTH_H, `WIDTH_HU: return offset[0];
         `WIDTH_W:            return offset != 2'b00;
         default:             return 1'b0;
      endcase
   endfunction

   // Natural alignment: drop the low bits a halfword/word access cannot use.
   function automatic logic [1:0] lane_offset(input logic [2:0] width, input logic [1:0] offset);
      case (width)
         `WIDTH_H, `WIDTH_HU: return {offset[1], 1'b0};
         `WIDTH_W:            return 2'b00;
         default:             return offset;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/common.vh
// Shared data-path widths and RISC-V load/store funct3 width codes.
`ifndef COMMON_VH
`define COMMON_VH

`define DATA_WIDTH     32
`define DATA_MEM_WIDTH 32

`define WIDTH_B  3'b000
`define WIDTH_H  3'b001
`define WIDTH_W  3'b010
`define WIDTH_BU 3'b100
`define WIDTH_HU 3'b101

`endif

// File: rtl/dmem_lane_align.sv
// +--------------------------------------------------------------------+
// | dmem_lane_align : byte-lane merge (store) / extract+extend (load)  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none
`include "common.vh"

module dmem_lane_align
   import dmem_responder_pkg::*;
(
   input  logic                   is_store,
   input  logic [2:0]             width,
   input  logic [1:0]             offset,
   input  logic [`DATA_WIDTH-1:0] data_in,
   input  logic [`DATA_WIDTH-1:0] old_word,
   output logic [`DATA_WIDTH-1:0] data_out
);

   logic [`DATA_WIDTH-1:0] shifted;
   logic [`DATA_WIDTH-1:0] merged;
   logic [`DATA_WIDTH-1:0] loaded;

   always_comb begin
      shifted = data_in >> {offset, 3'b000};
      merged  = old_word;
      loaded  = '0;
      case (width)
         `WIDTH_B, `WIDTH_BU: begin
            merged[{offset, 3'b000} +: 8] = data_in[7:0];
            loaded = (width == `WIDTH_B) ? {{24{shifted[7]}}, shifted[7:0]}
                                         : {24'd0, shifted[7:0]};
         end
         `WIDTH_H, `WIDTH_HU: begin
            merged[{offset[1], 4'b0000} +: 16] = data_in[15:0];
            loaded = (width == `WIDTH_H) ? {{16{shifted[15]}}, shifted[15:0]}
                                         : {16'd0, shifted[15:0]};
         end
         `WIDTH_W: begin
            merged = data_in;
            loaded = shifted;
         end
         default: begin
            merged = old_word;
            loaded = '0;
         end
      endcase
      data_out = is_store ? merged : loaded;
   end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// +--------------------------------------------------------------------+
// | dmem_responder : latency-configurable data memory responder        |
// | Option: DMEM_MISALIGN_TRAP_EN flags misaligned H/W as errors       |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none
`include "common.vh"

module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic                       req_we,
   input  logic [2:0]                 req_width,
   input  logic [`DATA_MEM_WIDTH-1:0] req_addr,
   input  logic [`DATA_WIDTH-1:0]     req_wdata,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [`DATA_WIDTH-1:0]     rsp_rdata,
   output logic                       rsp_err
);

   localparam int         AW        = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   state_t                     state;
   logic [3:0]                 cnt;
   logic                       we_q;
   logic [2:0]                 width_q;
   logic [`DATA_MEM_WIDTH-1:0] addr_q;
   logic [`DATA_WIDTH-1:0]     wdata_q;

   logic [`DATA_WIDTH-1:0]     mem [DEPTH_WORDS];

   // With LATENCY = 0 the access happens on the accept edge, so use live inputs.
   logic                       in_idle;
   logic                       op_we;
   logic [2:0]                 op_width;
   logic [`DATA_MEM_WIDTH-1:0] op_addr;
   logic [`DATA_WIDTH-1:0]     op_wdata;
   logic                       op_ok;
   logic [1:0]                 op_off;
   logic [AW-1:0]              idx;
   logic [`DATA_WIDTH-1:0]     word;
   logic [`DATA_WIDTH-1:0]     st_word;
   logic [`DATA_WIDTH-1:0]     ld_data;
   logic                       accept;
   logic                       enter_resp;
   logic                       unused_addr_bits;

   assign in_idle  = (state == ST_IDLE);
   assign op_we    = in_idle ? req_we    : we_q;
   assign op_width = in_idle ? req_width : width_q;
   assign op_addr  = in_idle ? req_addr  : addr_q;
   assign op_wdata = in_idle ? req_wdata : wdata_q;

`ifdef DMEM_MISALIGN_TRAP_EN
   assign op_ok = width_legal(op_width) && !misaligned(op_width, op_addr[1:0]);
`else
   assign op_ok = width_legal(op_width);
`endif

   assign op_off           = lane_offset(op_width, op_addr[1:0]);
   assign idx              = op_addr[AW+1:2];
   assign word             = mem[idx];
   assign unused_addr_bits = ^op_addr[`DATA_MEM_WIDTH-1:AW+2];

   assign accept     = req_valid && req_ready;
   assign enter_resp = (in_idle && accept && (LATENCY == 0)) ||
                       ((state == ST_WAIT) && (cnt == 4'd0));

   dmem_lane_align u_store_align (
      .is_store (1'b1),
      .width    (op_width),
      .offset   (op_off),
      .data_in  (op_wdata),
      .old_word (word),
      .data_out (st_word)
   );

   dmem_lane_align u_load_align (
      .is_store (1'b0),
      .width    (op_width),
      .offset   (op_off),
      .data_in  (word),
      .old_word (word),
      .data_out (ld_data)
   );

   // Storage survives reset; a store is committed only on the edge entering RESP.
   always_ff @(posedge clk) begin
      if (!rst && enter_resp && op_ok && op_we)
         mem[idx] <= st_word;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= 4'd0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         we_q      <= 1'b0;
         width_q   <= 3'd0;
         addr_q    <= '0;
         wdata_q   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  we_q      <= req_we;
                  width_q   <= req_width;
                  addr_q    <= req_addr;
                  wdata_q   <= req_wdata;
                  req_ready <= 1'b0;
                  if (LATENCY == 0) begin
                     state     <= ST_RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= !op_ok;
                     rsp_rdata <= (op_ok && !op_we) ? ld_data : '0;
                  end else begin
                     state <= ST_WAIT;
                     cnt   <= WAIT_INIT;
                  end
               end
            end
            ST_WAIT: begin
               if (cnt == 4'd0) begin
                  state     <= ST_RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= !op_ok;
                  rsp_rdata <= (op_ok && !op_we) ? ld_data : '0;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  state     <= ST_IDLE;
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            default: begin
               state     <= ST_IDLE;
               req_ready <= 1'b1;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// +--------------------------------------------------------------------+
// | tb_dmem_responder : directed + randomized check against a model    |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_dmem_responder;

   localparam int LAT   = 2;
   localparam int DEPTH = 1024;
   localparam int NWORD = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_width = 3'b010;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [31:0] mdl [DEPTH];

   typedef struct {
      logic        we;
      logic [2:0]  w;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] rd;
      logic        er;
   } op_t;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_width (req_width),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   always #5 clk = ~clk;

   // Reference: byte-addressed semantics on a word array, updated per access.
   function automatic void ref_access(input logic we, input logic [2:0] w,
                                      input logic [31:0] a, input logic [31:0] wd,
                                      output logic [31:0] rd, output logic er);
      int          idx;
      int          b;
      int          nbytes;
      logic        legal;
      logic        mis;
      logic [31:0] word;
      logic [31:0] mask;
      idx    = int'(a[11:2]);
      b      = int'(a[1:0]);
      legal  = (w == 3'b000) || (w == 3'b001) || (w == 3'b010) ||
               (w == 3'b100) || (w == 3'b101);
      nbytes = (w[1:0] == 2'b00) ? 1 : (w[1:0] == 2'b01) ? 2 : 4;
      mis    = ((nbytes == 2) && (b % 2 != 0)) || ((nbytes == 4) && (b != 0));
      er     = !legal;
`ifdef DMEM_MISALIGN_TRAP_EN
      er     = er || mis;
`endif
      rd = 32'd0;
      if (er) return;
      b    = b - (b % nbytes);
      word = mdl[idx];
      if (we) begin
         for (int k = 0; k < nbytes; k++)
            word[(b + k) * 8 +: 8] = wd[k * 8 +: 8];
         mdl[idx] = word;
      end else begin
         rd = word >> (8 * b);
         if (nbytes < 4) begin
            mask = (32'd1 << (8 * nbytes)) - 32'd1;
            rd   = rd & mask;
            if (!w[2] && rd[8 * nbytes - 1])
               rd = rd | ~mask;
         end
      end
   endfunction

   // One full transaction with rsp_ready held high; cyc counts cycles from acceptance.
   task automatic do_req(input logic we, input logic [2:0] w, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd,
                         output logic er, output int cyc);
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = we;
      req_width = w;
      req_addr  = a;
      req_wdata = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      cyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rsp_valid === 1'b1 || cyc > 40) break;
      end
      rd = rsp_rdata;
      er = rsp_err;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp += 4;
      if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
      if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
      if (rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); end
      if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
      rst = 1'b0;
   endtask

   task automatic test_init();
      logic [31:0] rd, wd, erd;
      logic        er, eer;
      int          cyc;
      for (int i = 0; i < NWORD; i++) begin
         wd = $urandom();
         ref_access(1'b1, 3'b010, 32'(i * 4), wd, erd, eer);
         do_req(1'b1, 3'b010, 32'(i * 4), wd, rd, er, cyc);
         n_cmp++;
         if (er !== 1'b0 || rd !== 32'd0 || cyc != LAT + 1) begin
            n_fail++;
            $display("FAIL init_store_%0d got err=%b rdata=%h lat=%0d want err=0 rdata=0 lat=%0d",
                     i, er, rd, cyc, LAT + 1);
         end
      end
   endtask

   task automatic test_directed();
      op_t         tbl[$];
      logic [31:0] rd, mrd;
      logic        er, mer;
      int          cyc;
      tbl.push_back(op_t'{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0});
      tbl.push_back(op_t'{1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0});
      tbl.push_back(op_t'{1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0});
      tbl.push_back(op_t'{1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0});
      tbl.push_back(op_t'{1'b0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 1'b0});
      tbl.push_back(op_t'{1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0});
      tbl.push_back(op_t'{1'b1, 3'b000, 32'h11, 32'h55, 32'h0, 1'b0});
      tbl.push_back(op_t'{1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0});
`ifdef DMEM_MISALIGN_TRAP_EN
      tbl.push_back(op_t'{1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1});
      tbl.push_back(op_t'{1'b1, 3'b001, 32'h11, 32'h1234, 32'h0, 1'b1});
`else
      tbl.push_back(op_t'{1'b0, 3'b010, 32'h12, 32'h0, 32'hDEAD55EF, 1'b0});
      tbl.push_back(op_t'{1'b1, 3'b001, 32'h13, 32'h1234, 32'h0, 1'b0});
      tbl.push_back(op_t'{1'b0, 3'b010, 32'h10, 32'h0, 32'h123455EF, 1'b0});
      tbl.push_back(op_t'{1'b1, 3'b010, 32'h10, 32'hDEAD55EF, 32'h0, 1'b0});
`endif
      tbl.push_back(op_t'{1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1});
      tbl.push_back(op_t'{1'b1, 3'b110, 32'h10, 32'h0BADF00D, 32'h0, 1'b1});
      tbl.push_back(op_t'{1'b1, 3'b111, 32'h10, 32'h0BADF00D, 32'h0, 1'b1});
      tbl.push_back(op_t'{1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0});
      foreach (tbl[i]) begin
         ref_access(tbl[i].we, tbl[i].w, tbl[i].a, tbl[i].wd, mrd, mer);
         do_req(tbl[i].we, tbl[i].w, tbl[i].a, tbl[i].wd, rd, er, cyc);
         n_cmp += 3;
         if (rd !== tbl[i].rd) begin n_fail++; $display("FAIL dir_%0d_rdata got %h want %h", i, rd, tbl[i].rd); end
         if (er !== tbl[i].er) begin n_fail++; $display("FAIL dir_%0d_err got %b want %b", i, er, tbl[i].er); end
         if (cyc != LAT + 1) begin n_fail++; $display("FAIL dir_%0d_latency got %0d want %0d", i, cyc, LAT + 1); end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] rd;
      logic        er;
      int          cyc;
      @(negedge clk);
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_width = 3'b010;
      req_addr  = 32'h10;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      cyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rsp_valid === 1'b1 || cyc > 40) break;
      end
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         req_valid = 1'b1;
         req_we    = 1'b1;
         req_width = 3'b010;
         req_addr  = 32'h10;
         req_wdata = 32'hCAFEF00D;
         n_cmp += 3;
         if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_%0d_rsp_valid got %b want 1", i, rsp_valid); end
         if (rsp_rdata !== 32'hDEAD55EF) begin n_fail++; $display("FAIL bp_%0d_rdata got %h want deadbeef-merged DEAD55EF", i, rsp_rdata); end
         if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_%0d_req_ready got %b want 0", i, req_ready); end
      end
      @(negedge clk);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      n_cmp += 2;
      if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_rsp_valid got %b want 0", rsp_valid); end
      if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_req_ready got %b want 1", req_ready); end
      do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er, cyc);
      n_cmp++;
      if (rd !== 32'hDEAD55EF || er !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_no_accept got rdata=%h err=%b want rdata=DEAD55EF err=0", rd, er);
      end
   endtask

   task automatic test_reset_in_wait();
      logic [31:0] rd;
      logic        er;
      int          cyc;
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_width = 3'b010;
      req_addr  = 32'h20;
      req_wdata = 32'h12345678;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_cmp += 4;
      if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstwait_rsp_valid got %b want 0", rsp_valid); end
      if (rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL rstwait_rdata got %h want 0", rsp_rdata); end
      if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL rstwait_err got %b want 0", rsp_err); end
      if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rstwait_req_ready got %b want 1", req_ready); end
      repeat (4) @(negedge clk);
      rst = 1'b0;
      do_req(1'b0, 3'b010, 32'h20, 32'h0, rd, er, cyc);
      n_cmp++;
      if (rd !== mdl[8] || er !== 1'b0) begin
         n_fail++;
         $display("FAIL rstwait_store_dropped got rdata=%h err=%b want rdata=%h err=0", rd, er, mdl[8]);
      end
   endtask

   task automatic test_random();
      logic [31:0] rd, erd, a, wd;
      logic        er, eer, we;
      logic [2:0]  w;
      int          cyc;
      for (int i = 0; i < 150; i++) begin
         we = 1'($urandom_range(0, 1));
         w  = ($urandom_range(0, 9) == 0) ? 3'(3 + 3 * $urandom_range(0, 1)) : 3'($urandom_range(0, 7));
         a  = ($urandom() & 32'hFFFF_F000) | 32'($urandom_range(0, NWORD - 1) << 2) |
              32'($urandom_range(0, 3));
         wd = $urandom();
         ref_access(we, w, a, wd, erd, eer);
         do_req(we, w, a, wd, rd, er, cyc);
         n_cmp += 3;
         if (rd !== erd) begin n_fail++; $display("FAIL rnd_%0d_rdata we=%b w=%b a=%h got %h want %h", i, we, w, a, rd, erd); end
         if (er !== eer) begin n_fail++; $display("FAIL rnd_%0d_err we=%b w=%b a=%h got %b want %b", i, we, w, a, er, eer); end
         if (cyc != LAT + 1) begin n_fail++; $display("FAIL rnd_%0d_latency got %0d want %0d", i, cyc, LAT + 1); end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_init();
      test_directed();
      test_backpressure();
      test_reset_in_wait();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
